learn_mode_seq: RTL and testbench
=================================

// Module: learn_mode_seq
// PURPOSE
//  Parametrised learning-mode sequencer: cues each song note (drives buzzer for its
//  duration), then waits for the player to press the matching key before advancing.
//  Counts wrong presses and elapsed seconds, and produces a 2-bit grade at song end.
//  Sits between the song library (external combinational lookup) and the buzzer/display.
// PARAMETERS
//  NOTE_W    4         note/key code width; code 0 = end-of-song marker
//  IDX_W     6         note index width
//  DUR_W     26        note duration width (clk cycles)
//  MAX_LEN   48        hard stop: song ends after MAX_LEN notes even without marker
//  TICK_DIV  100000000 clk cycles per elapsed-time second
//  MISS_W    8         mistake counter width (saturating)
//  GRADE_T0  30        seconds (plus mistakes) below which grade = 3
//  GRADE_T1  60        threshold for grade 2
//  GRADE_T2  90        threshold for grade 1; at or above = grade 0
// PORTS
//  clk          in   1       clock
//  rst          in   1       async active-high reset
//  start        in   1       pulse: begin song from index 0 (accepted in IDLE/DONE only)
//  key_valid    in   1       1-cycle pulse: a key was pressed
//  key_code     in   NOTE_W  pressed key, sampled when key_valid=1
//  note_index   out  IDX_W   address to song library
//  lib_note     in   NOTE_W  library note at note_index (same-cycle)
//  lib_dur      in   DUR_W   library duration at note_index (same-cycle)
//  note_to_play out  NOTE_W  note driven to buzzer
//  play_note    out  1       buzzer enable, high during CUE
//  note_strobe  out  1       1-cycle pulse on first CUE cycle of each note
//  expect_key   out  1       high in WAIT (player input expected)
//  mistakes     out  MISS_W  wrong presses this song, saturates at all-ones
//  elapsed_s    out  16      seconds since first note accepted, saturating
//  done         out  1       high in DONE
//  grade        out  2       valid when done=1; 3=best, 0=worst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0. Async reset mid-song aborts immediately.
//  FSM: IDLE -start-> LOAD; LOAD: if lib_note==0 or note_index==MAX_LEN -> DONE, else -> CUE.
//   CUE: play_note=1, note_to_play=lib_note; dur counter runs lib_dur cycles -> WAIT.
//        lib_dur==0 treated as 1 cycle. Key presses in CUE are ignored (not mistakes).
//   WAIT: key_valid & key_code==lib_note -> note_index+1, -> LOAD.
//         key_valid & mismatch -> mistakes+1 (saturate), stay WAIT.
//   DONE: done=1, grade held; start -> clear index/mistakes/elapsed -> LOAD.
//   start in LOAD/CUE/WAIT is ignored.
//  note_strobe asserts on the LOAD->CUE transition cycle+1 (first CUE cycle), one cycle wide.
//  Elapsed: prescaler counts TICK_DIV cycles in CUE/WAIT from first CUE of note 0; stops in DONE.
//  Grade: score = elapsed_s + mistakes (17-bit, no wrap); score<GRADE_T0 ->3, <T1 ->2,
//   <T2 ->1, else 0. Registered on entry to DONE; grade=0 outside DONE.
//  Index wrap: note_index never exceeds MAX_LEN; MAX_LEN must be < 2**IDX_W.
//  Empty song (lib_note==0 at index 0): LOAD->DONE, elapsed 0, grade 3.
// CONFIGURATION
//  LEARN_HINT_EN defined: in WAIT, if no correct key within 4*lib_dur cycles, re-enter CUE
//   (replay same note, note_strobe pulses again); replay does not count as a mistake.
//  Not defined: WAIT holds indefinitely; no hint counter is synthesised.
// TESTING
//  rst, start, song {5,3,0} dur 4, keys 5,3 in WAIT -> two 4-cycle CUE windows, done=1, mistakes=0, grade=3.
//  In WAIT for note 5, press 2,7 then 5 -> mistakes=2, advances only on 5.
//  Press correct key during CUE -> ignored; index unchanged, mistakes unchanged.
//  TICK_DIV=10, wait 700 cycles before final key, 0 mistakes -> elapsed_s~70, grade=1.
//  No end marker, MAX_LEN=3 -> DONE after index 3; rst asserted mid-CUE -> all outputs 0 same cycle.
//  LEARN_HINT_EN, dur 4, no key for 16 cycles -> note_strobe re-pulses, play_note high 4 cycles.

Source files
------------

// File: rtl/learn_mode_seq.sv
// learn_mode_seq: learning-mode song sequencer (cue note, wait for matching key).
// Ports: clk/rst, start, key_valid/key_code, note_index->lib_note/lib_dur,
//   note_to_play/play_note/note_strobe, expect_key, mistakes, elapsed_s,
//   done, grade.
// Optional: define LEARN_HINT_EN to replay a note after 4*lib_dur idle WAIT cycles.
module learn_mode_seq #(
  parameter int NOTE_W   = 4,
  parameter int IDX_W    = 6,
  parameter int DUR_W    = 26,
  parameter int MAX_LEN  = 48,
  parameter int TICK_DIV = 100000000,
  parameter int MISS_W   = 8,
  parameter int GRADE_T0 = 30,
  parameter int GRADE_T1 = 60,
  parameter int GRADE_T2 = 90
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              key_valid,
  input  logic [NOTE_W-1:0] key_code,
  output logic [IDX_W-1:0]  note_index,
  input  logic [NOTE_W-1:0] lib_note,
  input  logic [DUR_W-1:0]  lib_dur,
  output logic [NOTE_W-1:0] note_to_play,
  output logic              play_note,
  output logic              note_strobe,
  output logic              expect_key,
  output logic [MISS_W-1:0] mistakes,
  output logic [15:0]       elapsed_s,
  output logic              done,
  output logic [1:0]        grade
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [DUR_W-1:0]  dur_cnt;
  logic [PRE_W-1:0]  pre_cnt;

  logic [DUR_W-1:0]  dur_eff;
  logic              key_hit;
  logic              active;
  logic              sec_tick;
  logic              song_end;
  logic [16:0]       score;
  logic [1:0]        grade_nxt;

  // A zero duration still cues for one cycle.
  assign dur_eff  = (lib_dur == '0) ? DUR_W'(1) : lib_dur;
  assign key_hit  = key_valid && (key_code == lib_note);
  assign active   = (state == S_CUE) || (state == S_WAIT);
  assign sec_tick = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign song_end = (lib_note == '0) ||
                    (note_index == IDX_W'(MAX_LEN));
  assign score    = {1'b0, elapsed_s} + 17'(mistakes);

  always_comb begin
    grade_nxt = 2'd0;
    if (score < 17'(GRADE_T0))
      grade_nxt = 2'd3;
    else if (score < 17'(GRADE_T1))
      grade_nxt = 2'd2;
    else if (score < 17'(GRADE_T2))
      grade_nxt = 2'd1;
  end

`ifdef LEARN_HINT_EN
  logic [DUR_W+1:0] hint_cnt;
  logic [DUR_W+1:0] hint_lim;

  assign hint_lim = {dur_eff, 2'b00} - (DUR_W+2)'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      dur_cnt      <= '0;
      pre_cnt      <= '0;
      note_index   <= '0;
      note_to_play <= '0;
      play_note    <= 1'b0;
      note_strobe  <= 1'b0;
      expect_key   <= 1'b0;
      mistakes     <= '0;
      elapsed_s    <= '0;
      done         <= 1'b0;
      grade        <= 2'd0;
`ifdef LEARN_HINT_EN
      hint_cnt     <= '0;
`endif
    end else begin
      note_strobe <= 1'b0;

      // Seconds prescaler runs only while a note is cued or awaited.
      if (active) begin
        if (sec_tick) begin
          pre_cnt <= '0;
          if (elapsed_s != 16'hFFFF)
            elapsed_s <= elapsed_s + 16'd1;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            note_index <= '0;
            mistakes   <= '0;
            elapsed_s  <= '0;
            pre_cnt    <= '0;
            done       <= 1'b0;
            grade      <= 2'd0;
          end
        end
        S_LOAD: begin
          if (song_end) begin
            state <= S_DONE;
            done  <= 1'b1;
            grade <= grade_nxt;
          end else begin
            state        <= S_CUE;
            dur_cnt      <= dur_eff;
            play_note    <= 1'b1;
            note_strobe  <= 1'b1;
            note_to_play <= lib_note;
          end
        end
        S_CUE: begin
          if (dur_cnt <= DUR_W'(1)) begin
            state        <= S_WAIT;
            play_note    <= 1'b0;
            note_to_play <= '0;
            expect_key   <= 1'b1;
`ifdef LEARN_HINT_EN
            hint_cnt     <= '0;
`endif
          end else begin
            dur_cnt <= dur_cnt - DUR_W'(1);
          end
        end
        S_WAIT: begin
          if (key_hit) begin
            state      <= S_LOAD;
            expect_key <= 1'b0;
            note_index <= note_index + IDX_W'(1);
          end else begin
            if (key_valid && (mistakes != '1))
              mistakes <= mistakes + MISS_W'(1);
`ifdef LEARN_HINT_EN
            if (hint_cnt == hint_lim) begin
              state        <= S_CUE;
              dur_cnt      <= dur_eff;
              play_note    <= 1'b1;
              note_strobe  <= 1'b1;
              note_to_play <= lib_note;
              expect_key   <= 1'b0;
            end else begin
              hint_cnt <= hint_cnt + (DUR_W+2)'(1);
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_learn_mode_seq.sv
// tb_learn_mode_seq: directed self-checking bench for learn_mode_seq.
// Small TICK_DIV/MAX_LEN instance driven from a table-based song library.
module tb_learn_mode_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic [5:0]  note_index;
  logic [3:0]  lib_note;
  logic [25:0] lib_dur;
  logic [3:0]  note_to_play;
  logic        play_note;
  logic        note_strobe;
  logic        expect_key;
  logic [7:0]  mistakes;
  logic [15:0] elapsed_s;
  logic        done;
  logic [1:0]  grade;

  logic [3:0]  song_n [0:63];
  logic [25:0] song_d [0:63];

  int n_checks = 0;
  int n_errors = 0;

  int cue_cyc, strobes, pc;
  logic [3:0] cued;
  bit ok, got;

  always #5 clk = ~clk;

  assign lib_note = song_n[note_index];
  assign lib_dur  = song_d[note_index];

  learn_mode_seq #(
    .NOTE_W(4), .IDX_W(6), .DUR_W(26),
    .MAX_LEN(3), .TICK_DIV(10), .MISS_W(8),
    .GRADE_T0(30), .GRADE_T1(60), .GRADE_T2(90)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .key_valid(key_valid), .key_code(key_code),
    .note_index(note_index), .lib_note(lib_note),
    .lib_dur(lib_dur), .note_to_play(note_to_play),
    .play_note(play_note), .note_strobe(note_strobe),
    .expect_key(expect_key), .mistakes(mistakes),
    .elapsed_s(elapsed_s), .done(done), .grade(grade)
  );

  task automatic check(input string tag,
                       input logic [31:0] got_v,
                       input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic load_song(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    for (int i = 0; i < 64; i++) begin
      song_n[i] = '0;
      song_d[i] = 26'd4;
    end
    song_n[0] = a;
    song_n[1] = b;
    song_n[2] = c;
    song_n[3] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Runs until WAIT, counting cue cycles/strobes and capturing the cued note.
  task automatic wait_cue(output int cc, output int sc,
                          output logic [3:0] nt, output bit okv);
    cc = 0; sc = 0; nt = '0; okv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (expect_key) begin
        okv = 1;
        break;
      end
      if (play_note) cc++;
      if (note_strobe) begin
        sc++;
        nt = note_to_play;
      end
    end
    if (!okv) check("wait_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit okd;
    okd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        okd = 1;
        break;
      end
    end
    if (!okd) check("done_timeout", 0, 1);
  endtask

  initial begin
    load_song(4'd5, 4'd3, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    check("rst_play", play_note, 0);
    check("rst_done", done, 0);
    check("rst_grade", grade, 0);
    check("rst_idx", note_index, 0);
    check("rst_expect", expect_key, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic song {5,3,0}
    do_start();
    wait_cue(cue_cyc, strobes, cued, ok);
    check("t1_cue0_len", cue_cyc, 4);
    check("t1_cue0_strobe", strobes, 1);
    check("t1_cue0_note", cued, 5);
    press(4'd5);
    wait_cue(cue_cyc, strobes, cued, ok);
    check("t1_cue1_len", cue_cyc, 4);
    check("t1_cue1_note", cued, 3);
    check("t1_idx1", note_index, 1);
    press(4'd3);
    wait_done();
    check("t1_done_idx", note_index, 2);
    check("t1_mistakes", mistakes, 0);
    check("t1_grade", grade, 3);

    // Wrong presses, start ignored in WAIT
    do_start();
    check("t2_cleared_done", done, 0);
    wait_cue(cue_cyc, strobes, cued, ok);
    press(4'd2);
    check("t2_miss1", mistakes, 1);
    check("t2_idx_hold", note_index, 0);
    press(4'd7);
    check("t2_miss2", mistakes, 2);
    check("t2_still_wait", expect_key, 1);
    do_start();
    check("t2_start_ign_idx", note_index, 0);
    check("t2_start_ign_wait", expect_key, 1);
    press(4'd5);
    check("t2_advance", note_index, 1);
    wait_cue(cue_cyc, strobes, cued, ok);
    press(4'd3);
    wait_done();
    check("t2_final_miss", mistakes, 2);
    check("t2_grade", grade, 3);

    // Correct key during CUE is ignored
    do_start();
    @(negedge clk);
    check("t3_in_cue", play_note, 1);
    press(4'd5);
    check("t3_idx", note_index, 0);
    check("t3_miss", mistakes, 0);
    check("t3_still_cue", play_note, 1);
    wait_cue(cue_cyc, strobes, cued, ok);
    press(4'd5);
    wait_cue(cue_cyc, strobes, cued, ok);
    press(4'd3);
    wait_done();
    check("t3_done_miss", mistakes, 0);

    // Elapsed time: 4 CUE + 701 WAIT counting cycles -> 70 s
    load_song(4'd5, 4'd0, 4'd0, 4'd0);
    do_start();
    wait_cue(cue_cyc, strobes, cued, ok);
    repeat (700) @(negedge clk);
    press(4'd5);
    wait_done();
    check("t4_elapsed", elapsed_s, 70);
    check("t4_grade", grade, 1);

    // No end marker, MAX_LEN=3
    load_song(4'd1, 4'd2, 4'd3, 4'd4);
    do_start();
    for (int n = 0; n < 3; n++) begin
      wait_cue(cue_cyc, strobes, cued, ok);
      check("t5_note", cued, 32'(n + 1));
      press(4'(n + 1));
    end
    wait_done();
    check("t5_idx_max", note_index, 3);
    check("t5_done", done, 1);

    // Mistake saturation -> worst grade
    load_song(4'd6, 4'd0, 4'd0, 4'd0);
    do_start();
    wait_cue(cue_cyc, strobes, cued, ok);
    for (int n = 0; n < 260; n++) press(4'd1);
    check("t6_sat", mistakes, 255);
    press(4'd6);
    wait_done();
    check("t6_elapsed", elapsed_s, 26);
    check("t6_grade", grade, 0);

    // Empty song
    load_song(4'd0, 4'd0, 4'd0, 4'd0);
    do_start();
    wait_done();
    check("t7_idx", note_index, 0);
    check("t7_elapsed", elapsed_s, 0);
    check("t7_miss", mistakes, 0);
    check("t7_grade", grade, 3);

    // Async reset mid-CUE of second note
    load_song(4'd5, 4'd3, 4'd0, 4'd0);
    do_start();
    wait_cue(cue_cyc, strobes, cued, ok);
    press(4'd9);
    press(4'd5);
    @(negedge clk);
    check("t8_pre_cue", play_note, 1);
    check("t8_pre_idx", note_index, 1);
    rst = 1'b1;
    #1;
    check("t8_play", play_note, 0);
    check("t8_note", note_to_play, 0);
    check("t8_idx", note_index, 0);
    check("t8_miss", mistakes, 0);
    check("t8_expect", expect_key, 0);
    check("t8_strobe", note_strobe, 0);
    check("t8_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

`ifdef LEARN_HINT_EN
    load_song(4'd5, 4'd0, 4'd0, 4'd0);
    do_start();
    wait_cue(cue_cyc, strobes, cued, ok);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (note_strobe) begin
        got = 1;
        break;
      end
    end
    check("t9_replay_strobe", got, 1);
    pc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!play_note) break;
      pc++;
      @(negedge clk);
    end
    check("t9_replay_len", pc, 4);
    check("t9_miss", mistakes, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
